// File: rtl/c17_bist_tester.sv
// BIST controller for the c17 netlist: drives LFSR patterns, waits a settle time,
// compacts both outputs into a 16-bit MISR and compares against a golden signature.
module c17_bist_tester #(
  parameter int unsigned  PATTERNS = 32,
  parameter int unsigned  SETTLE   = 12,
  parameter logic [15:0]  GOLDEN   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  cut_in,
  input  logic [1:0]  cut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam int unsigned IDX_W = $clog2(PATTERNS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PATTERNS);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_APPLY  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [4:0]       cut_in_q, cut_in_d;
  logic [15:0]      sig_q, sig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [IDX_W-1:0] idx_inc;
  logic [15:0]      sig_upd;
  logic [4:0]       pat_next;

  always_comb begin
    idx_inc  = idx_q + 1'b1;
    sig_upd  = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ {14'b0, cut_out};
    // Index 0 is all-zero, which the LFSR cannot leave, so seed index 1 explicitly.
    pat_next = (cut_in_q == '0) ? 5'b00001 : {cut_in_q[3:0], cut_in_q[4] ^ cut_in_q[2]};
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    cut_in_d = cut_in_q;
    sig_d    = sig_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    case (state_q)
      S_IDLE: begin
        cut_in_d = '0;
        busy_d   = 1'b0;
        if (start) begin
          state_d  = S_APPLY;
          idx_d    = '0;
          cnt_d    = '0;
          sig_d    = '1;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_APPLY: begin
        if (cnt_q == SETTLE_LAST) begin
          sig_d = sig_upd;
          cnt_d = '0;
          idx_d = idx_inc;
          if (idx_inc == LAST_IDX) begin
            // Result is computed on entry so pass is already valid while done is high.
            state_d  = S_FINISH;
            cut_in_d = '0;
            done_d   = 1'b1;
            pass_d   = (sig_upd == GOLDEN);
          end else begin
            cut_in_d = pat_next;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        state_d  = S_IDLE;
        cut_in_d = '0;
        busy_d   = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        cut_in_d = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      cut_in_q <= '0;
      sig_q    <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      cut_in_q <= cut_in_d;
      sig_q    <= sig_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign cut_in    = cut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_c17_bist_tester.sv
// Self-checking bench for c17_bist_tester with a behavioural c17 and signature model.
module tb_c17_bist_tester;

  localparam int PAT_C    = 32;
  localparam int SETTLE_C = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_b, start_c;
  logic [4:0]  cin_a, cin_b, cin_c;
  logic [1:0]  cout_a, cout_b, cout_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;
  logic [15:0] sig_a, sig_b, sig_c;

  int total = 0;
  int bad   = 0;
  int fault_mode = 0;
  logic [63:0] noise_v = '0;

  // Zero-delay c17: inputs {N1,N2,N3,N6,N7}, outputs {N22,N23}.
  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n10, n11, n16, n19;
    n10 = ~(p[4] & p[2]);
    n11 = ~(p[2] & p[1]);
    n16 = ~(p[3] & n11);
    n19 = ~(n11 & p[0]);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  // mode 0: fault-free, 1: N22 stuck-at-1, 2: N23 stuck-at-0, 3: per-pattern noise.
  function automatic logic [1:0] resp(input logic [4:0] p, input int mode, input logic [63:0] nz);
    logic [1:0] o;
    o = c17(p);
    case (mode)
      1: o[1] = 1'b1;
      2: o[0] = 1'b0;
      3: o = o ^ nz[{p, 1'b0} +: 2];
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic [4:0] pat_at(input int i);
    logic [4:0] p;
    if (i == 0) return 5'b00000;
    p = 5'b00001;
    for (int k = 1; k < i; k++) p = {p[3:0], p[4] ^ p[2]};
    return p;
  endfunction

  function automatic logic [15:0] sig_of(input int npat, input int mode, input logic [63:0] nz);
    logic [15:0] s;
    logic fb;
    s = 16'hFFFF;
    for (int i = 0; i < npat; i++) begin
      fb = s[15];
      s  = s << 1;
      if (fb) s = s ^ 16'h1021;
      s = s ^ {14'd0, resp(pat_at(i), mode, nz)};
    end
    return s;
  endfunction

  localparam logic [15:0] GOLDEN_C = sig_of(PAT_C, 0, 64'd0);

  assign cout_a = c17(cin_a);
  assign cout_b = c17(cin_b);
  always_comb cout_c = resp(cin_c, fault_mode, noise_v);

  c17_bist_tester #(.PATTERNS(1), .SETTLE(2), .GOLDEN(16'hEFDF)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cut_in(cin_a), .cut_out(cout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));

  c17_bist_tester #(.PATTERNS(6), .SETTLE(3), .GOLDEN(16'h0000)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cut_in(cin_b), .cut_out(cout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));

  c17_bist_tester #(.PATTERNS(PAT_C), .SETTLE(SETTLE_C), .GOLDEN(GOLDEN_C)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .cut_in(cin_c), .cut_out(cout_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] pat;
  } seq_vec_t;

  typedef struct {
    int          mode;
    logic [63:0] nz;
    int          pulse_at;
    logic [15:0] exp_sig;
    bit          exp_pass;
  } run_vec_t;

  // One default-config run; optional ignored start pulse at negedge pulse_at.
  task automatic run_c(input run_vec_t v);
    int k, busy_n, seq_err;
    fault_mode = v.mode;
    noise_v    = v.nz;
    @(negedge clk) start_c = 1'b1;
    @(negedge clk) start_c = 1'b0;
    k = 1; busy_n = 0; seq_err = 0;
    while (!done_c && k < 1000) begin
      if (busy_c) busy_n++;
      if (k <= PAT_C * SETTLE_C && cin_c !== pat_at((k - 1) / SETTLE_C)) seq_err++;
      start_c = (k == v.pulse_at);
      @(negedge clk);
      k++;
    end
    start_c = 1'b0;
    if (busy_c) busy_n++;
    check("c_done_cycle", k, PAT_C * SETTLE_C + 1);
    check("c_pattern_seq", seq_err, 0);
    check("c_signature", sig_c, v.exp_sig);
    check("c_pass", pass_c, v.exp_pass);
    check("c_cut_in_finish", cin_c, 0);
    @(negedge clk);
    check("c_done_pulse", done_c, 0);
    check("c_busy_fall", busy_c, 0);
    check("c_busy_len", busy_n, PAT_C * SETTLE_C + 1);
    check("c_pass_hold", pass_c, v.exp_pass);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    seq_vec_t seq_tbl[6];
    run_vec_t runs[$];
    run_vec_t rv;
    int k, errs;
    bit seen_done;
    logic [15:0] sb;

    seq_tbl[0].pat = 5'b00000;
    seq_tbl[1].pat = 5'b00001;
    seq_tbl[2].pat = 5'b00010;
    seq_tbl[3].pat = 5'b00100;
    seq_tbl[4].pat = 5'b01001;
    seq_tbl[5].pat = 5'b10010;

    runs.push_back('{0, 64'd0, 0,  sig_of(PAT_C, 0, 64'd0), 1'b1});
    runs.push_back('{1, 64'd0, 50, sig_of(PAT_C, 1, 64'd0), sig_of(PAT_C, 1, 64'd0) == GOLDEN_C});
    runs.push_back('{2, 64'd0, 0,  sig_of(PAT_C, 2, 64'd0), sig_of(PAT_C, 2, 64'd0) == GOLDEN_C});
    for (int i = 0; i < 4; i++) begin
      rv.mode     = 3;
      rv.nz       = {$urandom, $urandom};
      rv.pulse_at = int'($urandom_range(2, 380));
      rv.exp_sig  = sig_of(PAT_C, 3, rv.nz);
      rv.exp_pass = (rv.exp_sig == GOLDEN_C);
      runs.push_back(rv);
    end

    // Reset with start asserted
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_c, 0);
    check("rst_done", done_c, 0);
    check("rst_pass", pass_c, 0);
    check("rst_cut_in", cin_c, 0);
    check("rst_sig", sig_c, 16'hFFFF);
    check("rst_busy_a", busy_a, 0);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", busy_c, 0);

    // Single pattern
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    k = 1;
    while (!done_a && k < 50) begin @(negedge clk); k++; end
    check("a_done_cycle", k, 3);
    check("a_sig", sig_a, 16'hEFDF);
    check("a_pass", pass_a, 1);
    repeat (5) @(negedge clk);
    check("a_sig_hold", sig_a, 16'hEFDF);
    check("a_pass_hold", pass_a, 1);

    // Start held high: back-to-back runs
    start_a = 1'b1;
    k = 0;
    while (!done_a && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    k = 1;
    while (!done_a && k < 50) begin @(negedge clk); k++; end
    check("a_backtoback_gap", k, 4);
    start_a = 1'b0;
    repeat (6) @(negedge clk);
    check("a_idle_after", busy_a, 0);

    // Pattern sequence
    start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      errs = 0;
      for (int j = 0; j < 3; j++) begin
        if (cin_b !== seq_tbl[i].pat) errs++;
        @(negedge clk);
      end
      check($sformatf("b_pattern_%0d", i), errs, 0);
    end
    sb = sig_of(6, 0, 64'd0);
    check("b_done", done_b, 1);
    check("b_cut_in_zero", cin_b, 0);
    check("b_sig", sig_b, sb);
    check("b_pass", pass_b, sb == 16'h0000);

    // Default runs: fault-free, stuck faults, randomized noise
    foreach (runs[i]) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      run_c(runs[i]);
    end

    // Abort mid-run
    fault_mode = 0; noise_v = '0;
    @(negedge clk) start_c = 1'b1;
    @(negedge clk) start_c = 1'b0;
    k = 1; seen_done = 1'b0;
    while (k < 100) begin
      if (done_c) seen_done = 1'b1;
      @(negedge clk); k++;
    end
    check("abort_running", busy_c, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy_c, 0);
    check("abort_done", done_c, 0);
    check("abort_pass", pass_c, 0);
    check("abort_cut_in", cin_c, 0);
    check("abort_sig", sig_c, 16'hFFFF);
    repeat (5) begin
      @(negedge clk);
      if (done_c || busy_c) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    run_c(runs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
